// File: rtl/ph_drain_sched.sv
// ph_drain_sched: drains the four parasite-to-host FIFOs (R1..R4) through their
// shared host read port and presents each byte on a channel-tagged stream.
//
// Output handshake: out_valid is raised with out_data/out_chan already stable.
// All three hold until the rising edge where out_valid & out_ready is high.
// out_valid never drops and the payload never changes before that edge.
module ph_drain_sched #(
  parameter int R4_PRIORITY = 1,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             h_phi2,
  input  logic             h_rst,
  input  logic [3:0]       enable,
  input  logic [3:0]       h_data_available,
  input  logic [7:0]       h_data,
  output logic [3:0]       h_selectData,
  output logic             h_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [1:0]       out_chan,
  output logic             busy,
  output logic [CNT_W-1:0] drained_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES);
  localparam bit         USE_PRI  = (R4_PRIORITY != 0);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       chan_q, chan_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [2:0]       gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] req;
  logic [1:0] win;
  logic       found;
  logic [2:0] idx;

  assign req = h_data_available & enable;

  // Winner pick: R4 first when prioritised, else first requester from rr_ptr up.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 3'd0;
    if (USE_PRI && req[3]) begin
      win = 2'd3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = {1'b0, rr_ptr_q} + 3'(i);
        if (USE_PRI) begin
          // Pool is channels 0..2, so wrap modulo 3.
          if (idx >= 3'd3) idx = idx - 3'd3;
        end else begin
          idx = {1'b0, idx[1:0]};
        end
        if (!found && req[idx[1:0]] && !(USE_PRI && i == 3)) begin
          win   = idx[1:0];
          found = 1'b1;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 2'd0;
      rr_ptr_q <= 2'd0;
      chan_q   <= 2'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      gap_q    <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      chan_q   <= chan_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req != 4'd0) state_d = S_READ;
      S_READ: state_d = S_HOLD;
      S_HOLD: if (out_ready) state_d = S_GAP;
      S_GAP:  if (gap_q <= 3'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch the winner, capture the byte, count accepts.
  always_comb begin
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    chan_d   = chan_q;
    data_d   = data_q;
    valid_d  = valid_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req != 4'd0) sel_d = win;
      end
      S_READ: begin
        data_d  = h_data;
        chan_d  = sel_q;
        valid_d = 1'b1;
        if (USE_PRI) begin
          // A priority win by R4 leaves the pool pointer untouched.
          if (sel_q != 2'd3) rr_ptr_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        end else begin
          rr_ptr_d = sel_q + 2'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q != 3'd0) gap_d = gap_q - 3'd1;
      end
      default: ;
    endcase
  end

  // Outputs: the read strobe and select are live only in the READ cycle.
  always_comb begin
    h_rd         = (state_q == S_READ);
    h_selectData = (state_q == S_READ) ? (4'b0001 << sel_q) : 4'b0000;
    busy         = (state_q != S_IDLE);
    dbg_state    = state_q;
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_chan      = chan_q;
  assign drained_count = cnt_q;

endmodule

// File: tb/tb_ph_drain_sched.sv
// Bench for ph_drain_sched: FIFO-quad model, arbitration reference model and
// an output scoreboard, driven by directed and randomised steps.
module tb_ph_drain_sched;

  localparam int R4P  = 1;
  localparam int POOL = (R4P != 0) ? 3 : 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  enable = 4'd0;
  logic [3:0]  avail = 4'd0;
  logic [7:0]  h_data;
  logic [3:0]  h_sel;
  logic        h_rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        busy;
  logic [15:0] drained_count;
  logic [1:0]  dbg_state;

  ph_drain_sched #(.R4_PRIORITY(R4P), .GAP_CYCLES(1), .CNT_W(16)) dut (
    .h_phi2(clk), .h_rst(rst), .enable(enable), .h_data_available(avail),
    .h_data(h_data), .h_selectData(h_sel), .h_rd(h_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan), .busy(busy),
    .drained_count(drained_count), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO quad model
  logic [7:0] fq0[$], fq1[$], fq2[$], fq3[$];
  logic [7:0] head_r [4];

  function automatic int fsize(input int ch);
    case (ch)
      0: return fq0.size();
      1: return fq1.size();
      2: return fq2.size();
      default: return fq3.size();
    endcase
  endfunction

  function automatic logic [7:0] fhead(input int ch);
    case (ch)
      0: return fq0[0];
      1: return fq1[0];
      2: return fq2[0];
      default: return fq3[0];
    endcase
  endfunction

  task automatic update_env();
    for (int i = 0; i < 4; i++) begin
      avail[i]  = (fsize(i) > 0);
      head_r[i] = (fsize(i) > 0) ? fhead(i) : 8'h00;
    end
  endtask

  task automatic fpush(input int ch, input logic [7:0] b);
    case (ch)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      2: fq2.push_back(b);
      default: fq3.push_back(b);
    endcase
    update_env();
  endtask

  task automatic fpop(input int ch);
    case (ch)
      0: if (fq0.size() > 0) void'(fq0.pop_front());
      1: if (fq1.size() > 0) void'(fq1.pop_front());
      2: if (fq2.size() > 0) void'(fq2.pop_front());
      default: if (fq3.size() > 0) void'(fq3.pop_front());
    endcase
    update_env();
  endtask

  task automatic fclear();
    fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
    update_env();
  endtask

  always_comb begin
    h_data = 8'h00;
    for (int i = 0; i < 4; i++) if (h_sel[i]) h_data = head_r[i];
  end

  // Reference arbitration: priority R4, otherwise scan the pool from ptr.
  function automatic int ref_winner(input logic [3:0] r, input int ptr);
    if (R4P != 0 && r[3]) return 3;
    for (int k = 0; k < POOL; k++) begin
      int c;
      c = (ptr + k) % POOL;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Scoreboard state
  logic [9:0] exp_q[$];
  int         chan_log[$];
  int         model_ptr = 0;
  int         acc_cnt = 0;
  int         rd_count = 0;
  logic [3:0] req_prev = 4'd0;
  bit         pop_pend = 1'b0;
  int         pop_ch = 0;

  // Monitor at negedge: arbitration, read strobe rules, output bytes, counter.
  always @(negedge clk) begin
    int w;
    logic [9:0] e;
    logic [7:0] d;
    if (rst) begin
      req_prev = 4'd0;
    end else begin
      chk("rd_while_valid", 32'(h_rd & out_valid), 32'd0);
      chk("drained_count", 32'(drained_count), 32'(acc_cnt[15:0]));
      if (h_rd) begin
        w = ref_winner(req_prev, model_ptr);
        chk("h_selectData", 32'(h_sel), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
          d = (fsize(w) > 0) ? fhead(w) : 8'h00;
          exp_q.push_back({2'(w), d});
          if (!(R4P != 0 && w == 3)) model_ptr = (w + 1) % POOL;
        end
        for (int i = 0; i < 4; i++) if (h_sel[i]) pop_ch = i;
        pop_pend = 1'b1;
        rd_count++;
      end else begin
        chk("sel_when_no_rd", 32'(h_sel), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_chan", 32'(out_chan), 32'(e[9:8]));
          chk("out_data", 32'(out_data), 32'(e[7:0]));
        end
        chan_log.push_back(int'(out_chan));
        acc_cnt++;
      end
      req_prev = avail & enable;
    end
  end

  // FIFO pop lands just after the edge where h_rd was sampled.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      fpop(pop_ch);
      pop_pend = 1'b0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    chan_log.delete();
    acc_cnt   = 0;
    model_ptr = 0;
    pop_pend  = 1'b0;
    fclear();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drained(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      done = !busy && exp_q.size() == 0 && (avail & enable) == 4'd0 && !pop_pend;
      if (!done) begin
        tick();
        n++;
      end
    end
    chk("wait_drained_timeout", 32'(done), 32'd1);
  endtask

  int rdc;
  int idx3;
  int exp_order [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

  initial begin
    update_env();
    // Reset values
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_h_rd", 32'(h_rd), 32'd0);
    chk("rst_sel", 32'(h_sel), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_drained", 32'(drained_count), 32'd0);
    do_reset();

    // Single byte from R2, cycle-exact
    enable = 4'hF;
    out_ready = 1'b1;
    tick();
    rdc = rd_count;
    fpush(1, 8'h5A);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_read_rd", 32'(h_rd), 32'd1);
    chk("t1_read_sel", 32'(h_sel), 32'h2);
    chk("t1_read_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_hold_valid", 32'(out_valid), 32'd1);
    chk("t1_hold_rd", 32'(h_rd), 32'd0);
    chk("t1_hold_data", 32'(out_data), 32'h5A);
    chk("t1_hold_chan", 32'(out_chan), 32'd1);
    tick();
    chk("t1_gap_valid", 32'(out_valid), 32'd0);
    chk("t1_gap_busy", 32'(busy), 32'd1);
    chk("t1_count", 32'(drained_count), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_one_read", 32'(rd_count - rdc), 32'd1);

    // Round robin over R1..R3, three bytes each
    do_reset();
    enable = 4'h0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 3; c++) fpush(c, 8'(16 * c + k));
    enable = 4'hF;
    wait_drained(200);
    chk("t2_count", 32'(chan_log.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      chk("t2_order", (i < chan_log.size()) ? 32'(chan_log[i]) : 32'hFFFF, 32'(exp_order[i]));

    // R4 arrives while R1/R2 stream
    do_reset();
    enable = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fpush(0, 8'(8'h20 + k));
      fpush(1, 8'(8'h30 + k));
    end
    repeat (9) tick();
    fpush(3, 8'hE4);
    wait_drained(200);
    idx3 = -1;
    foreach (chan_log[i]) if (chan_log[i] == 3) idx3 = i;
    chk("t3_r4_served", 32'(idx3 > 0 && idx3 + 1 < chan_log.size()), 32'd1);
    if (idx3 > 0 && idx3 + 1 < chan_log.size())
      chk("t3_rr_resume", 32'(chan_log[idx3 + 1]), (chan_log[idx3 - 1] == 0) ? 32'd1 : 32'd0);

    // Back-pressure: consumer stalls 10 cycles
    do_reset();
    enable = 4'hF;
    out_ready = 1'b0;
    rdc = rd_count;
    fpush(0, 8'hC3);
    fpush(1, 8'h3C);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      chk("t4_stall_data", 32'(out_data), 32'hC3);
      chk("t4_stall_chan", 32'(out_chan), 32'd0);
    end
    chk("t4_no_extra_rd", 32'(rd_count - rdc), 32'd1);
    out_ready = 1'b1;
    wait_drained(100);
    chk("t4_rd_per_byte", 32'(rd_count - rdc), 32'd2);

    // All disabled, then R3 only
    do_reset();
    enable = 4'h0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) fpush(c, 8'(8'h40 + 16 * c + k));
    rdc = rd_count;
    repeat (50) tick();
    chk("t5_no_rd", 32'(rd_count - rdc), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    enable = 4'b0100;
    wait_drained(200);
    chk("t5_r3_reads", 32'(rd_count - rdc), 32'd3);
    chk("t5_r1_left", 32'(fsize(0)), 32'd3);
    chk("t5_r4_left", 32'(fsize(3)), 32'd3);
    enable = 4'hF;
    wait_drained(300);

    // Reset while a byte is held
    do_reset();
    enable = 4'hF;
    out_ready = 1'b0;
    fpush(2, 8'h77);
    wait_valid(20);
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sel", 32'(h_sel), 32'd0);
    chk("t6_count", 32'(drained_count), 32'd0);
    do_reset();
    enable = 4'hF;
    out_ready = 1'b1;
    fpush(2, 8'h78);
    wait_drained(50);
    chk("t6_rerun_count", 32'(drained_count), 32'd1);

    // Randomised traffic, enables and back-pressure
    do_reset();
    enable = 4'hF;
    rdc = rd_count;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) fpush(int'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 15) == 0) enable = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    enable = 4'hF;
    out_ready = 1'b1;
    wait_drained(3000);
    chk("t7_fifos_empty", 32'(fsize(0) + fsize(1) + fsize(2) + fsize(3)), 32'd0);
    chk("t7_reads_eq_accepts", 32'(rd_count - rdc), 32'(acc_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ph_drain_sched.md
Name: ph_drain_sched

Overview:
- Host-side scheduler that autonomously drains the four parasite-to-host register FIFOs (R1..R4) through their shared host read port.
- Arbitrates between channels with data available, issues one read at a time, and presents each byte on a single valid/ready output stream tagged with its channel.
- Sits between the parasite-to-host FIFO quad and host-side consumers (a bus bridge or soft host) that do not implement the 6502-style register polling.

Parameters:
- R4_PRIORITY, 1, 1 = channel 3 (R4) has strict priority over the round-robin pool; 0 = all four channels in round-robin.
- GAP_CYCLES, 1, idle cycles after each read before re-arbitrating, so h_data_available can settle; legal range 1..7.
- CNT_W, 16, width of the drained-byte counter.

Ports:
- h_phi2  input  1  host clock; all state updates on rising edge.
- h_rst  input  1  reset, active-high, asynchronous assert; one clock only.
- enable  input  4  per-channel drain enable; bit n gates channel n.
- h_data_available  input  4  per-channel data-available flags from the FIFO quad.
- h_data  input  8  muxed FIFO head data for the currently selected channel.
- h_selectData  output  4  one-hot channel select to the FIFO quad; 0 when idle.
- h_rd  output  1  host read strobe; pops the selected FIFO at the rising edge it is sampled high.
- out_valid  output  1  output byte valid.
- out_ready  input  1  consumer accepts the byte when out_valid & out_ready.
- out_data  output  8  captured byte.
- out_chan  output  2  channel index of out_data (0 = R1 .. 3 = R4).
- busy  output  1  high in any state other than IDLE.
- drained_count  output  CNT_W  total bytes accepted by the consumer; wraps.

Behaviour:
- Reset (async): state = IDLE, h_selectData = 0, h_rd = 0, out_valid = 0, out_data = 0, out_chan = 0, busy = 0, drained_count = 0, rr_ptr = 0, gap counter = 0.
- Eligible channels: req = h_data_available & enable.
- FSM states: IDLE, READ, HOLD, GAP.
- IDLE:
  - If req != 0, choose a winner and go to READ.
  - Winner selection: when R4_PRIORITY = 1 and req[3] = 1, the winner is channel 3. Otherwise the winner is the first set bit of req scanning from rr_ptr upward, wrapping modulo 4. When R4_PRIORITY = 1, the round-robin scan covers channels 0..2 only.
  - Winner index is registered as sel.
- READ (exactly one cycle):
  - h_selectData = one-hot(sel), h_rd = 1.
  - At the end of the cycle: out_data <= h_data, out_chan <= sel, out_valid <= 1, rr_ptr <= sel + 1 (mod 4; mod 3 in the R4_PRIORITY pool, and not updated when channel 3 wins by priority). Next state HOLD.
- HOLD:
  - h_rd = 0, h_selectData = 0, out_valid = 1.
  - out_data and out_chan are stable until out_valid & out_ready.
  - On acceptance: out_valid <= 0, drained_count increments (wraps at 2^CNT_W), gap counter loads GAP_CYCLES, next state GAP.
- GAP: count down; when the counter reaches 0, go to IDLE.
- Latency:
  - With out_ready tied high and GAP_CYCLES = 1, each byte takes 4 cycles (IDLE, READ, HOLD, GAP).
  - out_valid rises 2 cycles after req first appears while in IDLE.
- h_rd is asserted for exactly one cycle per byte and never while out_valid = 1. Exactly one read is issued per accepted byte.
- Enable or flag change:
  - If enable or h_data_available drops after the winner is registered, the READ still completes; this is harmless because the flag was sampled high in IDLE.
  - Changes during HOLD or GAP do not affect the byte already held.
- All channels disabled: remain in IDLE with h_rd = 0 and no FIFO pops.
- Reset mid-operation: all outputs return to reset values immediately. Any held byte is discarded and drained_count is not incremented.
- R3 two-byte mode needs no special handling: R3 becomes eligible only when its available flag is set.

Test Plan:
- Reset, then preload R2 with 0x5A and enable = 4'b1111 → exactly one h_rd pulse with h_selectData = 4'b0010; out_data = 0x5A, out_chan = 1; drained_count = 1 after acceptance.
- R1, R2 and R3 each hold 3 bytes, R4_PRIORITY = 1, out_ready = 1 → channel service order is 0,1,2,0,1,2,0,1,2 and every byte arrives in FIFO order.
- R4 receives a byte while R1 and R2 are streaming → the next arbitration selects channel 3; round robin then resumes at the channel following the last pool winner.
- out_ready held low for 10 cycles after out_valid rises → out_data/out_chan stable, no further h_rd; one h_rd per byte once out_ready goes high.
- enable = 4'b0000 with all FIFOs non-empty for 50 cycles → h_rd never asserted; enabling only bit 2 drains R3 alone.
- Assert h_rst during HOLD → out_valid, busy and h_selectData are 0 in the same cycle; drained_count is unchanged from its pre-byte value after a re-run from reset (0); FSM restarts cleanly.
